// File: rtl/sevenseg_pkg.sv
// Shared definitions for the seven-segment scan driver: segment patterns
// (active-high, {a,b,c,d,e,f,g}) and the scan FSM state type.
package sevenseg_pkg;

  typedef enum logic {
    GUARD,
    DRIVE
  } scan_state_t;

  localparam logic [6:0] SEG_0    = 7'b1111110;
  localparam logic [6:0] SEG_1    = 7'b0110000;
  localparam logic [6:0] SEG_2    = 7'b1101101;
  localparam logic [6:0] SEG_3    = 7'b1111001;
  localparam logic [6:0] SEG_4    = 7'b0110011;
  localparam logic [6:0] SEG_5    = 7'b1011011;
  localparam logic [6:0] SEG_6    = 7'b1011111;
  localparam logic [6:0] SEG_7    = 7'b1110000;
  localparam logic [6:0] SEG_8    = 7'b1111111;
  localparam logic [6:0] SEG_9    = 7'b1111011;
  localparam logic [6:0] SEG_DASH = 7'b0000001;
  localparam logic [6:0] SEG_OFF  = 7'b0000000;

endpackage

// File: rtl/bcd_to_7seg.sv
// BCD code to active-high segment pattern; codes 10..15 show a dash.
module bcd_to_7seg
  import sevenseg_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  always_comb begin
    case (code)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/sevenseg_scan_driver.sv
// Time-multiplexed N-digit seven-segment driver with guard interval,
// frame-aligned double buffering, leading-zero blanking and per-digit blink.
module sevenseg_scan_driver
  import sevenseg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned DIGIT_CYCLES   = 50000,
  parameter int unsigned GUARD_CYCLES   = 500,
  parameter int unsigned BLINK_FRAMES   = 64,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    blank_lz,
  input  logic [NUM_DIGITS-1:0]   blink_en,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic                    frame_tick
);

  localparam int unsigned SW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [SW-1:0] SLOT_LAST  = SW'(DIGIT_CYCLES - 1);
  localparam logic [SW-1:0] GUARD_LAST = SW'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
  localparam scan_state_t   SLOT_START = (GUARD_CYCLES == 0) ? DRIVE : GUARD;

  scan_state_t state_q, state_d;
  logic [SW-1:0] slot_q, slot_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          slot_last, frame_wrap;

  logic [4*NUM_DIGITS-1:0] pend_bcd, act_bcd;
  logic [NUM_DIGITS-1:0]   pend_dp, act_dp;
  logic [BW-1:0]           blink_cnt;
  logic                    blink_phase;
  logic [NUM_DIGITS-1:0]   blink_s;
  logic                    lz_s;

  logic [3:0]            cur_code;
  logic [6:0]            cur_seg;
  logic [NUM_DIGITS-1:0] lz_mask;
  logic                  zero_run;
  logic                  drive;
  logic [NUM_DIGITS-1:0] an_h;
  logic [6:0]            seg_h;
  logic                  dp_h;
  logic                  tick_h;

  assign slot_last  = (slot_q == SLOT_LAST);
  assign frame_wrap = slot_last && (idx_q == IDX_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SLOT_START;
      slot_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    slot_d  = slot_last ? '0 : slot_q + 1'b1;
    idx_d   = idx_q;
    state_d = state_q;
    if (slot_last) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    case (state_q)
      GUARD:   if (slot_q == GUARD_LAST) state_d = DRIVE;
      DRIVE:   if (slot_last) state_d = SLOT_START;
      default: state_d = SLOT_START;
    endcase
  end

  // A load landing on the frame boundary bypasses pending so it shows this frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_bcd <= '0;
      pend_dp  <= '0;
      act_bcd  <= '0;
      act_dp   <= '0;
    end else begin
      if (load) begin
        pend_bcd <= bcd_in;
        pend_dp  <= dp_in;
      end
      if (frame_wrap) begin
        act_bcd <= load ? bcd_in : pend_bcd;
        act_dp  <= load ? dp_in : pend_dp;
      end
    end
  end

  // Blank controls are sampled once per slot so a digit never blanks mid-slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      blink_s     <= '0;
      lz_s        <= 1'b0;
    end else begin
      if (frame_wrap) begin
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
      if (slot_last) begin
        blink_s <= blink_en;
        lz_s    <= blank_lz;
      end
    end
  end

  assign cur_code = act_bcd[{idx_q, 2'b00} +: 4];

  bcd_to_7seg u_dec (
    .code (cur_code),
    .seg  (cur_seg)
  );

  always_comb begin
    lz_mask  = '0;
    zero_run = 1'b1;
    for (int unsigned i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_run   = zero_run & (act_bcd[4*i +: 4] == 4'd0);
      lz_mask[i] = zero_run;
    end
  end

  always_comb begin
    drive = (state_q == DRIVE)
          && !(lz_s && lz_mask[idx_q])
          && !(blink_phase && blink_s[idx_q]);
    an_h  = '0;
    if (drive) an_h[idx_q] = 1'b1;
    seg_h  = drive ? cur_seg : SEG_OFF;
    dp_h   = drive && act_dp[idx_q];
    tick_h = (idx_q == '0) && (slot_q == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_out     <= AN_ACTIVE_LOW ? '1 : '0;
      seg_out    <= SEG_ACTIVE_LOW ? '1 : '0;
      dp_out     <= SEG_ACTIVE_LOW;
      frame_tick <= 1'b0;
    end else begin
      an_out     <= AN_ACTIVE_LOW ? ~an_h : an_h;
      seg_out    <= SEG_ACTIVE_LOW ? ~seg_h : seg_h;
      dp_out     <= SEG_ACTIVE_LOW ? ~dp_h : dp_h;
      frame_tick <= tick_h;
    end
  end

endmodule
